// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared widths and FSM state type for the RV32I register-file writeback path
//
// Purpose: common constants and the writeback arbiter state enum.
// Ports:   none (package).
package rv32i_pkg;

   localparam int XLEN       = 32;
   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } wb_state_e;

endpackage

// File: rtl/rv32i_rr_arbiter2.sv
// rtl/rv32i_rr_arbiter2.sv - two-input round-robin grant with a one-bit priority pointer
//
// Purpose: grants at most one of two requesters per cycle; after a grant the
//          other side becomes favoured, so contention alternates A/B.
// Ports:   clk, rst     - clock, synchronous active-high reset (prio -> A)
//          en           - grants allowed this cycle
//          req_a, req_b - request inputs
//          gnt_a, gnt_b - combinational one-hot (or zero) grants
module rv32i_rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic req_a,
   input  logic req_b,
   output logic gnt_a,
   output logic gnt_b
);

   // 0 = A favoured, 1 = B favoured
   logic prio_q;
   logic prio_d;

   always_comb begin
      gnt_a  = en && req_a && (!req_b || !prio_q);
      gnt_b  = en && req_b && (!req_a ||  prio_q);
      prio_d = prio_q;
      // Whichever side won, the other side is favoured next.
      if (gnt_a) begin
         prio_d = 1'b1;
      end else if (gnt_b) begin
         prio_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else begin
         prio_q <= prio_d;
      end
   end

endmodule

// File: rtl/rv32i_rf_wb_arbiter.sv
// rtl/rv32i_rf_wb_arbiter.sv - ALU/LSU writeback arbiter with register-file zero-fill
//
// Purpose: after reset (or init_req) writes zero to x1..x31, then arbitrates
//          ALU and LSU writebacks round-robin into one registered write port.
// Ports:   clk, rst                       - clock, synchronous active-high reset
//          init_req                       - one-cycle request to re-clear the file
//          alu_wb_valid/ready/reg/data    - ALU writeback handshake
//          lsu_wb_valid/ready/reg/data    - LSU writeback handshake
//          write_enable/reg/data          - registered register-file write port
//          init_done                      - fill complete, writebacks accepted
module rv32i_rf_wb_arbiter
   import rv32i_pkg::*;
#(
   parameter bit INIT_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  init_req,
   input  logic                  alu_wb_valid,
   output logic                  alu_wb_ready,
   input  logic [REG_ADDR_W-1:0] alu_wb_reg,
   input  logic [XLEN-1:0]       alu_wb_data,
   input  logic                  lsu_wb_valid,
   output logic                  lsu_wb_ready,
   input  logic [REG_ADDR_W-1:0] lsu_wb_reg,
   input  logic [XLEN-1:0]       lsu_wb_data,
   output logic                  write_enable,
   output logic [REG_ADDR_W-1:0] write_reg,
   output logic [XLEN-1:0]       write_data,
   output logic                  init_done
);

   localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_REGS - 1);
   localparam logic [REG_ADDR_W-1:0] FIRST_REG = REG_ADDR_W'(1);

   wb_state_e             state_q, state_d;
   logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
   logic                  init_done_q, init_done_d;
   logic                  write_enable_q, write_enable_d;
   logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
   logic [XLEN-1:0]       write_data_q, write_data_d;

   logic arb_en;
   logic gnt_alu;
   logic gnt_lsu;

   // Readies are also masked by rst so a requester never sees a handshake
   // that the reset is about to discard.
   assign arb_en = init_done_q && (state_q == ST_RUN) && !init_req && !rst;

   rv32i_rr_arbiter2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .en    (arb_en),
      .req_a (alu_wb_valid),
      .req_b (lsu_wb_valid),
      .gnt_a (gnt_alu),
      .gnt_b (gnt_lsu)
   );

   assign alu_wb_ready = gnt_alu;
   assign lsu_wb_ready = gnt_lsu;

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      init_done_d    = init_done_q;
      write_enable_d = 1'b0;
      write_reg_d    = write_reg_q;
      write_data_d   = write_data_q;

      case (state_q)
         ST_INIT: begin
            // init_req is deliberately ignored here: the fill never restarts.
            init_done_d    = 1'b0;
            write_enable_d = 1'b1;
            write_reg_d    = cnt_q;
            write_data_d   = '0;
            if (cnt_q == LAST_REG) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + FIRST_REG;
            end
         end
         ST_RUN: begin
            if (init_req) begin
               state_d     = ST_INIT;
               cnt_d       = FIRST_REG;
               init_done_d = 1'b0;
            end else begin
               init_done_d = 1'b1;
               // x0 writes are accepted but dropped; address/data hold.
               if (gnt_alu && (alu_wb_reg != '0)) begin
                  write_enable_d = 1'b1;
                  write_reg_d    = alu_wb_reg;
                  write_data_d   = alu_wb_data;
               end else if (gnt_lsu && (lsu_wb_reg != '0)) begin
                  write_enable_d = 1'b1;
                  write_reg_d    = lsu_wb_reg;
                  write_data_d   = lsu_wb_data;
               end
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = FIRST_REG;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= INIT_ON_RESET ? ST_INIT : ST_RUN;
         cnt_q          <= FIRST_REG;
         init_done_q    <= !INIT_ON_RESET;
         write_enable_q <= 1'b0;
         write_reg_q    <= '0;
         write_data_q   <= '0;
      end else begin
         state_q        <= state_d;
         cnt_q          <= cnt_d;
         init_done_q    <= init_done_d;
         write_enable_q <= write_enable_d;
         write_reg_q    <= write_reg_d;
         write_data_q   <= write_data_d;
      end
   end

   assign write_enable = write_enable_q;
   assign write_reg    = write_reg_q;
   assign write_data   = write_data_q;
   assign init_done    = init_done_q;

endmodule
